// File: rtl/mux_2_1_pkg.sv
// Shared types and defaults for the registered 2:1 selector.
package mux_2_1_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;

  // Select encoding: 0 picks in0, 1 picks in1.
  typedef enum logic {
    SEL_IN0 = 1'b0,
    SEL_IN1 = 1'b1
  } sel_e;

endpackage

// File: rtl/mux_2_1_if.sv
// Data/select bundle for mux_2_1; master drives the inputs, slave returns out.
interface mux_2_1_if
  import mux_2_1_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             sel;
  logic [WIDTH-1:0] out;

  modport master (
    output in0,
    output in1,
    output sel,
    input  out
  );

  modport slave (
    input  in0,
    input  in1,
    input  sel,
    output out
  );

endinterface

// File: rtl/mux_2_1_comb.sv
// Reusable combinational 2:1 mux; the ternary keeps y_c known when in0==in1
// even if sel is X.
module mux_2_1_comb
  import mux_2_1_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] y_c
);

  // Select in1 when sel is high, otherwise in0.
  always_comb begin
    y_c = (sel == SEL_IN1) ? in1 : in0;
  end

endmodule

// File: rtl/mux_2_1.sv
// Registered 2:1 selector: out takes the selected input one edge later.
module mux_2_1
  import mux_2_1_pkg::*;
#(
  parameter int unsigned    WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic      clk,
  input  logic      rst,
  mux_2_1_if.slave  bus
);

  logic [WIDTH-1:0] sel_data_c;

  mux_2_1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .in0 (bus.in0),
    .in1 (bus.in1),
    .sel (bus.sel),
    .y_c (sel_data_c)
  );

  // Capture the selection each edge; synchronous reset takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out <= RESET_VAL;
    end else begin
      bus.out <= sel_data_c;
    end
  end

endmodule

// File: tb/tb_mux_2_1.sv
// Self-checking bench for mux_2_1 at WIDTH=1 and WIDTH=8/RESET_VAL=8'hA5.
module tb_mux_2_1;

  logic clk;
  logic rst1;
  logic rst8;
  int   total;
  int   bad;

  logic       q1[$];
  logic [7:0] q8[$];

  mux_2_1_if #(.WIDTH(1)) bus1 ();
  mux_2_1_if #(.WIDTH(8)) bus8 ();

  mux_2_1 #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  mux_2_1 #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one WIDTH=1 vector, record its expected out, advance past the edge.
  task automatic apply1(input logic r, input logic a, input logic b,
                        input logic s, input logic exp);
    rst1     = r;
    bus1.in0 = a;
    bus1.in1 = b;
    bus1.sel = s;
    q1.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  // Drive one WIDTH=8 vector, record its expected out, advance past the edge.
  task automatic apply8(input logic r, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] exp);
    rst8     = r;
    bus8.in0 = a;
    bus8.in1 = b;
    bus8.sel = s;
    q8.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp;
    for (int i = 0; i < 2; i++) begin
      apply1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      exp = q1.pop_front();
      total++;
      if (bus1.out !== exp) begin
        bad++;
        $display("FAIL reset_edge%0d got=%b want=%b", i, bus1.out, exp);
      end
    end
  endtask

  task automatic test_select();
    logic [2:0] vec [4];
    logic       exp;
    vec[0] = 3'b000;
    vec[1] = 3'b011;
    vec[2] = 3'b111;
    vec[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      apply1(1'b0, vec[i][2], vec[i][1], vec[i][0],
             vec[i][0] ? vec[i][1] : vec[i][2]);
      exp = q1.pop_front();
      total++;
      if (bus1.out !== exp) begin
        bad++;
        $display("FAIL select_%0d got=%b want=%b", i, bus1.out, exp);
      end
    end
  endtask

  task automatic test_dont_care();
    logic exp;
    apply1(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    exp = q1.pop_front();
    total++;
    if (bus1.out !== exp) begin
      bad++;
      $display("FAIL dont_care_sel0 got=%b want=%b", bus1.out, exp);
    end
    apply1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp = q1.pop_front();
    total++;
    if (bus1.out !== exp) begin
      bad++;
      $display("FAIL dont_care_sel1 got=%b want=%b", bus1.out, exp);
    end
  endtask

  task automatic test_latency();
    logic exp;
    apply1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp = q1.pop_front();
    total++;
    if (bus1.out !== exp) begin
      bad++;
      $display("FAIL latency_pre got=%b want=%b", bus1.out, exp);
    end
    #2;
    bus1.sel = 1'b1;
    q1.push_back(1'b1);
    #1;
    total++;
    if (bus1.out !== 1'b0) begin
      bad++;
      $display("FAIL latency_hold got=%b want=%b", bus1.out, 1'b0);
    end
    @(posedge clk);
    #1;
    exp = q1.pop_front();
    total++;
    if (bus1.out !== exp) begin
      bad++;
      $display("FAIL latency_post got=%b want=%b", bus1.out, exp);
    end
  endtask

  task automatic test_mid_reset();
    logic exp;
    logic r [3];
    logic w [3];
    r[0] = 1'b0; w[0] = 1'b1;
    r[1] = 1'b1; w[1] = 1'b0;
    r[2] = 1'b0; w[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply1(r[i], 1'b0, 1'b1, 1'b1, w[i]);
      exp = q1.pop_front();
      total++;
      if (bus1.out !== exp) begin
        bad++;
        $display("FAIL mid_reset_%0d got=%b want=%b", i, bus1.out, exp);
      end
    end
  endtask

  task automatic test_wide();
    logic [7:0] exp;
    apply8(1'b1, 8'h3C, 8'hC3, 1'b1, 8'hA5);
    exp = q8.pop_front();
    total++;
    if (bus8.out !== exp) begin
      bad++;
      $display("FAIL wide_reset got=%h want=%h", bus8.out, exp);
    end
    apply8(1'b0, 8'h3C, 8'hC3, 1'b0, 8'h3C);
    exp = q8.pop_front();
    total++;
    if (bus8.out !== exp) begin
      bad++;
      $display("FAIL wide_sel0 got=%h want=%h", bus8.out, exp);
    end
    apply8(1'b0, 8'h3C, 8'hC3, 1'b1, 8'hC3);
    exp = q8.pop_front();
    total++;
    if (bus8.out !== exp) begin
      bad++;
      $display("FAIL wide_sel1 got=%h want=%h", bus8.out, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] exp;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      apply8(1'b0, a, b, s, s ? b : a);
      exp = q8.pop_front();
      total++;
      if (bus8.out !== exp) begin
        bad++;
        $display("FAIL b2b_%0d got=%h want=%h", i, bus8.out, exp);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst1     = 1'b1;
    rst8     = 1'b1;
    bus1.in0 = 1'b0;
    bus1.in1 = 1'b0;
    bus1.sel = 1'b0;
    bus8.in0 = 8'h00;
    bus8.in1 = 8'h00;
    bus8.sel = 1'b0;
    @(negedge clk);
    test_reset();
    test_select();
    test_dont_care();
    test_latency();
    test_mid_reset();
    test_wide();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
